// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive parser: FSM states, datapath
// commands from the header FSM to the realigner, and tkeep helpers.
package udp_rx_pkg;

    typedef enum logic [1:0] {
        HDR,
        PAY,
        DROP,
        FLUSH
    } state_t;

    // What the realigner should do with the current input beat this cycle.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_SHORT,
        CMD_PAY,
        CMD_FLUSH
    } cmd_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [3:0]  HDR_LAST_WORD  = 4'd10;

    function automatic logic [3:0] keep_for_n(input logic [2:0] n);
        logic [3:0] keep;
        case (n)
            3'd1:    keep = 4'b0001;
            3'd2:    keep = 4'b0011;
            3'd3:    keep = 4'b0111;
            3'd4:    keep = 4'b1111;
            default: keep = 4'b0000;
        endcase
        return keep;
    endfunction

    // Right-justified keep patterns only; anything else counts as a full word.
    function automatic logic [2:0] n_for_keep(input logic [3:0] keep);
        logic [2:0] n;
        case (keep)
            4'b0001: n = 3'd1;
            4'b0011: n = 3'd2;
            4'b0111: n = 3'd3;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/udp_rx_realign.sv
// Payload realigner: keeps the 2-byte residual, shifts the stream by 2 bytes,
// owns the registered output beat and emits the trailing flush beat.
module udp_rx_realign
    import udp_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  cmd_t        cmd,
    input  logic [31:0] s_data,
    input  logic [3:0]  s_keep,
    input  logic        s_last,
    output logic        out_ready,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready
);

    logic [15:0] res;
    logic [15:0] held;
    logic [2:0]  held_n;
    logic [2:0]  n;

    logic        load;
    logic [31:0] nxt_data;
    logic [3:0]  nxt_keep;
    logic        nxt_last;
    logic        res_load;
    logic        hold_load;
    logic [15:0] nxt_held;
    logic [2:0]  nxt_held_n;

    assign out_ready = ~m_valid | m_ready;
    assign n         = n_for_keep(s_keep);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        load       = 1'b0;
        nxt_data   = '0;
        nxt_keep   = 4'b1111;
        nxt_last   = 1'b0;
        res_load   = 1'b0;
        hold_load  = 1'b0;
        nxt_held   = '0;
        nxt_held_n = '0;
        unique case (cmd)
            CMD_LOAD: begin
                res_load = 1'b1;
            end
            CMD_SHORT: begin
                res_load = 1'b1;
                load     = 1'b1;
                nxt_data = {16'h0000, s_data[15:0]};
                nxt_keep = 4'b0011;
                nxt_last = 1'b1;
            end
            CMD_PAY: begin
                load = 1'b1;
                if (!s_last) begin
                    res_load = 1'b1;
                    nxt_data = {res, s_data[31:16]};
                end else begin
                    // R plus n tail bytes: up to 4 bytes fit now, the rest spill into FLUSH.
                    case (n)
                        3'd1: begin
                            nxt_data = {8'h00, res, s_data[7:0]};
                            nxt_keep = 4'b0111;
                            nxt_last = 1'b1;
                        end
                        3'd2: begin
                            nxt_data = {res, s_data[15:0]};
                            nxt_last = 1'b1;
                        end
                        3'd3: begin
                            nxt_data   = {res, s_data[23:8]};
                            hold_load  = 1'b1;
                            nxt_held   = {8'h00, s_data[7:0]};
                            nxt_held_n = 3'd1;
                        end
                        default: begin
                            nxt_data   = {res, s_data[31:16]};
                            hold_load  = 1'b1;
                            nxt_held   = s_data[15:0];
                            nxt_held_n = 3'd2;
                        end
                    endcase
                end
            end
            CMD_FLUSH: begin
                load     = out_ready;
                nxt_data = {16'h0000, held};
                nxt_keep = keep_for_n(held_n);
                nxt_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            res     <= '0;
            held    <= '0;
            held_n  <= '0;
        end else begin
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= nxt_data;
                m_keep  <= nxt_keep;
                m_last  <= nxt_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (res_load) begin
                res <= s_data[15:0];
            end
            if (hold_load) begin
                held   <= nxt_held;
                held_n <= nxt_held_n;
            end
        end
    end

endmodule

// File: rtl/udp_rx_parser.sv
// Ethernet II / IPv4 / UDP receive filter: checks the 42-byte header, drops
// non-matching frames and forwards the 2-byte-realigned payload.
module udp_rx_parser
    import udp_rx_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0102,
    parameter logic [15:0] LOCAL_PORT = 16'd5000,
    parameter bit          CHECK_IP   = 1'b1
) (
    input  logic        clk_32,
    input  logic        reset_32_n,
    input  logic [31:0] axis_tdata_in,
    input  logic [3:0]  axis_tkeep_in,
    input  logic        axis_tvalid_in,
    input  logic        axis_tlast_in,
    output logic        axis_tready_out,
    output logic [31:0] axis_tdata_out,
    output logic [3:0]  axis_tkeep_out,
    output logic        axis_tvalid_out,
    output logic        axis_tlast_out,
    input  logic        axis_tready_in,
    output logic [31:0] udp_src_ip,
    output logic [15:0] udp_src_port,
    output logic [15:0] drop_cnt
);

    state_t      state;
    logic [3:0]  idx;
    logic        mismatch;
    logic [31:0] ip_shadow;
    logic [15:0] port_shadow;

    logic        out_ready;
    logic        fire;
    logic        at_w10;
    logic        runt;
    logic        beat_bad;
    logic        bad;
    logic        hdr_ok;
    logic        drop_hit;
    cmd_t        cmd;

    always_comb begin
        beat_bad = 1'b0;
        case (idx)
            4'd3: beat_bad = (axis_tdata_in[31:16] != ETHERTYPE_IPV4) ||
                             (axis_tdata_in[15:8]  != IPV4_VER_IHL);
            4'd5: beat_bad = (axis_tdata_in[7:0] != IP_PROTO_UDP);
            4'd7: beat_bad = CHECK_IP && (axis_tdata_in[15:0]  != LOCAL_IP[31:16]);
            4'd8: beat_bad = CHECK_IP && (axis_tdata_in[31:16] != LOCAL_IP[15:0]);
            4'd9: beat_bad = (axis_tdata_in[31:16] != LOCAL_PORT);
            default: beat_bad = 1'b0;
        endcase
    end

    assign at_w10 = (idx == HDR_LAST_WORD);
    assign runt   = axis_tlast_in && (!at_w10 || axis_tkeep_in != 4'b1111);
    assign bad    = mismatch | beat_bad;

    // In HDR only w10 can produce an output beat, so only w10 waits for the output register.
    always_comb begin
        axis_tready_out = 1'b1;
        case (state)
            HDR:     axis_tready_out = at_w10 ? out_ready : 1'b1;
            DROP:    axis_tready_out = 1'b1;
            PAY:     axis_tready_out = out_ready;
            FLUSH:   axis_tready_out = 1'b0;
            default: axis_tready_out = 1'b1;
        endcase
    end

    assign fire     = axis_tvalid_in && axis_tready_out;
    assign hdr_ok   = (state == HDR) && fire && at_w10 && !runt && !bad;
    assign drop_hit = (state == HDR) && fire && (runt || (at_w10 && bad));

    always_comb begin
        cmd = CMD_NONE;
        case (state)
            HDR:     if (hdr_ok) cmd = axis_tlast_in ? CMD_SHORT : CMD_LOAD;
            PAY:     if (fire)   cmd = CMD_PAY;
            FLUSH:   cmd = CMD_FLUSH;
            default: cmd = CMD_NONE;
        endcase
    end

    always_ff @(posedge clk_32 or negedge reset_32_n) begin
        if (!reset_32_n) begin
            state        <= HDR;
            idx          <= '0;
            mismatch     <= 1'b0;
            ip_shadow    <= '0;
            port_shadow  <= '0;
            udp_src_ip   <= '0;
            udp_src_port <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (fire) begin
                        case (idx)
                            4'd6: ip_shadow[31:16] <= axis_tdata_in[15:0];
                            4'd7: ip_shadow[15:0]  <= axis_tdata_in[31:16];
                            4'd8: port_shadow      <= axis_tdata_in[15:0];
                            default: ;
                        endcase
                        if (runt || at_w10) begin
                            idx      <= '0;
                            mismatch <= 1'b0;
                        end else begin
                            idx      <= idx + 4'd1;
                            mismatch <= bad;
                        end
                        if (!runt && at_w10 && !axis_tlast_in) begin
                            state <= bad ? DROP : PAY;
                        end
                        if (hdr_ok) begin
                            udp_src_ip   <= ip_shadow;
                            udp_src_port <= port_shadow;
                        end
                    end
                end
                DROP: begin
                    if (fire && axis_tlast_in) state <= HDR;
                end
                PAY: begin
                    if (fire && axis_tlast_in) begin
                        state <= (n_for_keep(axis_tkeep_in) > 3'd2) ? FLUSH : HDR;
                    end
                end
                FLUSH: begin
                    if (out_ready) state <= HDR;
                end
                default: state <= HDR;
            endcase
        end
    end

    always_ff @(posedge clk_32 or negedge reset_32_n) begin
        if (!reset_32_n) begin
            drop_cnt <= '0;
        end else if (drop_hit && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    udp_rx_realign u_realign (
        .clk       (clk_32),
        .rst_n     (reset_32_n),
        .cmd       (cmd),
        .s_data    (axis_tdata_in),
        .s_keep    (axis_tkeep_in),
        .s_last    (axis_tlast_in),
        .out_ready (out_ready),
        .m_data    (axis_tdata_out),
        .m_keep    (axis_tkeep_out),
        .m_valid   (axis_tvalid_out),
        .m_last    (axis_tlast_out),
        .m_ready   (axis_tready_in)
    );

endmodule

// File: tb/tb_udp_rx_parser.sv
// Scoreboard bench for udp_rx_parser: frames are built byte by byte, expected
// payload beats are queued at send time and a negedge monitor pops and compares.
module tb_udp_rx_parser;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk_32 = 1'b0;
    logic        reset_32_n;
    logic [31:0] axis_tdata_in;
    logic [3:0]  axis_tkeep_in;
    logic        axis_tvalid_in;
    logic        axis_tlast_in;
    logic        axis_tready_out;
    logic [31:0] axis_tdata_out;
    logic [3:0]  axis_tkeep_out;
    logic        axis_tvalid_out;
    logic        axis_tlast_out;
    logic        axis_tready_in;
    logic [31:0] udp_src_ip;
    logic [15:0] udp_src_port;
    logic [15:0] drop_cnt;

    beat_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_drop = 0;
    logic [31:0] exp_ip   = '0;
    logic [15:0] exp_port = '0;
    int          frame_no = 1;
    bit          ready_toggle = 1'b0;
    bit          stall_prev = 1'b0;
    beat_t       held_beat;
    beat_t       mon_exp;

    localparam logic [31:0] GOOD_IP   = 32'hC0A8_0102;
    localparam logic [15:0] GOOD_PORT = 16'd5000;

    always #5 clk_32 = ~clk_32;

    udp_rx_parser dut (
        .clk_32          (clk_32),
        .reset_32_n      (reset_32_n),
        .axis_tdata_in   (axis_tdata_in),
        .axis_tkeep_in   (axis_tkeep_in),
        .axis_tvalid_in  (axis_tvalid_in),
        .axis_tlast_in   (axis_tlast_in),
        .axis_tready_out (axis_tready_out),
        .axis_tdata_out  (axis_tdata_out),
        .axis_tkeep_out  (axis_tkeep_out),
        .axis_tvalid_out (axis_tvalid_out),
        .axis_tlast_out  (axis_tlast_out),
        .axis_tready_in  (axis_tready_in),
        .udp_src_ip      (udp_src_ip),
        .udp_src_port    (udp_src_port),
        .drop_cnt        (drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: constant 1, or toggling 1010 when ready_toggle is set.
    initial begin
        axis_tready_in = 1'b1;
        forever begin
            @(posedge clk_32);
            #1;
            if (ready_toggle) axis_tready_in = ~axis_tready_in;
            else              axis_tready_in = 1'b1;
        end
    end

    // Monitor: samples mid-cycle, so the values seen are those the next posedge uses.
    always @(negedge clk_32) begin
        if (!reset_32_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", 64'(axis_tvalid_out), 64'd1);
                check("stall_beat_held", 64'({axis_tdata_out, axis_tkeep_out, axis_tlast_out}),
                      64'(held_beat));
            end
            if (axis_tvalid_out && axis_tready_in) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h/%0h/%0b, expected no output",
                             axis_tdata_out, axis_tkeep_out, axis_tlast_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_beat", 64'({axis_tdata_out, axis_tkeep_out, axis_tlast_out}),
                          64'(mon_exp));
                end
            end
            stall_prev = axis_tvalid_out && !axis_tready_in;
            held_beat  = '{data: axis_tdata_out, keep: axis_tkeep_out, last: axis_tlast_out};
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the beat transferred.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit acc;
        int guard;
        axis_tvalid_in = 1'b1;
        axis_tdata_in  = d;
        axis_tkeep_in  = k;
        axis_tlast_in  = l;
        guard = 0;
        do begin
            @(negedge clk_32);
            acc = axis_tready_out;
            @(posedge clk_32);
            #1;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_beat: input beat not accepted within 1000 cycles");
        end
    endtask

    task automatic send_frame(input logic [15:0] etype, input logic [7:0] proto,
                              input logic [31:0] dst_ip, input logic [15:0] dst_port,
                              input int pay_len, input int trunc, input int abort_words,
                              input bit accept);
        logic [7:0]  b[$];
        logic [7:0]  p[$];
        logic [15:0] ip_len;
        logic [15:0] udp_len;
        logic [31:0] s_ip;
        logic [15:0] s_port;
        logic [31:0] d;
        int          nw;
        int          r;
        s_ip    = 32'h0A00_0000 + 32'(frame_no);
        s_port  = 16'h1000 + 16'(frame_no);
        frame_no++;
        ip_len  = 16'(28 + pay_len);
        udp_len = 16'(8 + pay_len);
        for (int i = 0; i < 12; i++) b.push_back(8'(8'hA0 + i));
        b.push_back(etype[15:8]);  b.push_back(etype[7:0]);
        b.push_back(8'h45);        b.push_back(8'h00);
        b.push_back(ip_len[15:8]); b.push_back(ip_len[7:0]);
        b.push_back(8'h12);        b.push_back(8'h34);
        b.push_back(8'h40);        b.push_back(8'h00);
        b.push_back(8'h40);        b.push_back(proto);
        b.push_back(8'h00);        b.push_back(8'h00);
        for (int i = 3; i >= 0; i--) b.push_back(s_ip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(dst_ip[8*i +: 8]);
        b.push_back(s_port[15:8]);   b.push_back(s_port[7:0]);
        b.push_back(dst_port[15:8]); b.push_back(dst_port[7:0]);
        b.push_back(udp_len[15:8]);  b.push_back(udp_len[7:0]);
        b.push_back(8'h00);          b.push_back(8'h00);
        for (int i = 0; i < pay_len; i++) begin
            p.push_back(8'(i + 1));
            b.push_back(8'(i + 1));
        end
        if (trunc > 0) begin
            while (b.size() > trunc) void'(b.pop_back());
        end
        if (accept) begin
            nw = (p.size() + 3) / 4;
            for (int w = 0; w < nw; w++) begin
                r = (w == nw - 1) ? (p.size() - 4 * w) : 4;
                d = '0;
                for (int j = 0; j < r; j++) d = {d[23:0], p[4 * w + j]};
                exp_q.push_back('{data: d, keep: 4'((1 << r) - 1), last: (w == nw - 1)});
            end
            exp_ip   = s_ip;
            exp_port = s_port;
        end else begin
            exp_drop++;
        end
        nw = (b.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            if (abort_words > 0 && w == abort_words) return;
            r = (w == nw - 1) ? (b.size() - 4 * w) : 4;
            d = '0;
            for (int j = 0; j < r; j++) d = {d[23:0], b[4 * w + j]};
            send_beat(d, 4'((1 << r) - 1), (w == nw - 1));
        end
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;
    endtask

    task automatic good_frame(input int pay_len);
        send_frame(16'h0800, 8'd17, GOOD_IP, GOOD_PORT, pay_len, 0, 0, 1'b1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(posedge clk_32);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected beats still queued, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk_32);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
        check({tag, "_src_ip"}, 64'(udp_src_ip), 64'(exp_ip));
        check({tag, "_src_port"}, 64'(udp_src_port), 64'(exp_port));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_32_n     = 1'b0;
        axis_tvalid_in = 1'b0;
        axis_tdata_in  = '0;
        axis_tkeep_in  = '0;
        axis_tlast_in  = 1'b0;
        #12;
        check("reset_tvalid", 64'(axis_tvalid_out), 64'd0);
        check("reset_tdata", 64'(axis_tdata_out), 64'd0);
        check("reset_tkeep", 64'(axis_tkeep_out), 64'd0);
        check("reset_tlast", 64'(axis_tlast_out), 64'd0);
        check("reset_tready", 64'(axis_tready_out), 64'd1);
        check_status("reset");
        #10;
        reset_32_n = 1'b1;
        @(posedge clk_32);
        #1;

        // 8-byte payload: two full output words.
        good_frame(8);
        drain();
        check_status("pay8");

        // 5-byte payload: tail spills into a one-cycle FLUSH.
        good_frame(5);
        check("flush_tready_low", 64'(axis_tready_out), 64'd0);
        @(posedge clk_32);
        #1;
        check("after_flush_tready", 64'(axis_tready_out), 64'd1);
        drain();
        check_status("pay5");

        // Wrong port, wrong ethertype, then a good frame.
        send_frame(16'h0800, 8'd17, GOOD_IP, 16'd5001, 6, 0, 0, 1'b0);
        send_frame(16'h0806, 8'd17, GOOD_IP, GOOD_PORT, 6, 0, 0, 1'b0);
        drain();
        check_status("two_drops");
        good_frame(8);
        drain();
        check_status("after_drops");

        // Runt ending on w6, then a 3-byte payload frame.
        send_frame(16'h0800, 8'd17, GOOD_IP, GOOD_PORT, 8, 28, 0, 1'b0);
        drain();
        check_status("runt_w6");
        good_frame(3);
        drain();
        check_status("pay3");

        // w10 last with short keep, wrong IP, wrong protocol, mismatch ending at w10.
        send_frame(16'h0800, 8'd17, GOOD_IP, GOOD_PORT, 8, 43, 0, 1'b0);
        send_frame(16'h0800, 8'd17, 32'hC0A8_0103, GOOD_PORT, 4, 0, 0, 1'b0);
        send_frame(16'h0800, 8'd6, GOOD_IP, GOOD_PORT, 6, 0, 0, 1'b0);
        send_frame(16'h0800, 8'd17, GOOD_IP, 16'd5001, 2, 0, 0, 1'b0);
        drain();
        check_status("edge_drops");
        good_frame(2);
        good_frame(6);
        drain();
        check_status("pay2_pay6");

        // Back-pressure 1010 during long and odd-length payloads.
        ready_toggle = 1'b1;
        good_frame(64);
        good_frame(5);
        good_frame(3);
        good_frame(6);
        drain();
        ready_toggle = 1'b0;
        check_status("stalled");

        // Reset in the middle of a payload.
        ready_toggle = 1'b1;
        send_frame(16'h0800, 8'd17, GOOD_IP, GOOD_PORT, 64, 0, 18, 1'b1);
        axis_tvalid_in = 1'b0;
        @(posedge clk_32);
        #3;
        reset_32_n = 1'b0;
        #1;
        check("midrst_tvalid", 64'(axis_tvalid_out), 64'd0);
        check("midrst_tdata", 64'(axis_tdata_out), 64'd0);
        check("midrst_tkeep", 64'(axis_tkeep_out), 64'd0);
        check("midrst_tlast", 64'(axis_tlast_out), 64'd0);
        check("midrst_tready", 64'(axis_tready_out), 64'd1);
        exp_q.delete();
        exp_drop     = 0;
        exp_ip       = '0;
        exp_port     = '0;
        ready_toggle = 1'b0;
        check_status("midrst");
        repeat (2) @(posedge clk_32);
        #3;
        reset_32_n = 1'b1;
        @(posedge clk_32);
        #1;
        good_frame(8);
        drain();
        check_status("after_midrst");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
